// File: rtl/idli_sqi_m.sv
`default_nettype none
// ============================================================================
// idli_sqi_m : SQI (quad-SPI) master moving one 16-bit word per request.
// Revision  : 1.0
// ============================================================================
module idli_sqi_m (
   input  logic        i_sqi_gck,
   input  logic        i_sqi_rst_n,
   input  logic        i_sqi_req,
   input  logic        i_sqi_wr,
   input  logic [15:0] i_sqi_addr,
   output logic        o_sqi_ack,
   input  logic [3:0]  i_sqi_wr_data,
   output logic [3:0]  o_sqi_rd_data,
   output logic        o_sqi_data_vld,
   output logic        o_sqi_done,
   output logic        o_sqi_cs_n,
   output logic        o_sqi_sck_en,
   output logic [3:0]  o_sqi_sio_out,
   output logic        o_sqi_sio_oe,
   input  logic [3:0]  i_sqi_sio_in
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_ADDR  = 3'd2,
      S_DUMMY = 3'd3,
      S_DATA  = 3'd4
   } state_t;

   localparam logic [3:0] C_CMD_RD = 4'h3;
   localparam logic [3:0] C_CMD_WR = 4'h2;

   state_t      state, state_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic        wr_q;
   logic [15:0] addr_q;
   logic [3:0]  addr_nib;

   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         state  <= S_IDLE;
         cnt    <= 2'd0;
         wr_q   <= 1'b0;
         addr_q <= 16'h0000;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == S_IDLE && i_sqi_req) begin
            wr_q   <= i_sqi_wr;
            addr_q <= i_sqi_addr;
         end
      end
   end

   // Address goes out most-significant nibble first.
   always_comb begin
      addr_nib = 4'h0;
      case (cnt)
         2'd0:    addr_nib = addr_q[15:12];
         2'd1:    addr_nib = addr_q[11:8];
         2'd2:    addr_nib = addr_q[7:4];
         default: addr_nib = addr_q[3:0];
      endcase
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt + 2'd1;
      o_sqi_ack      = 1'b0;
      o_sqi_rd_data  = 4'h0;
      o_sqi_data_vld = 1'b0;
      o_sqi_done     = 1'b0;
      o_sqi_cs_n     = 1'b0;
      o_sqi_sio_out  = 4'h0;
      o_sqi_sio_oe   = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nxt    = 2'd0;
            o_sqi_cs_n = 1'b1;
            // Gated by reset so ack stays low while reset is held.
            o_sqi_ack  = i_sqi_req & i_sqi_rst_n;
            if (i_sqi_req) state_nxt = S_CMD;
         end
         S_CMD: begin
            o_sqi_sio_oe  = 1'b1;
            o_sqi_sio_out = (cnt == 2'd0) ? 4'h0 : (wr_q ? C_CMD_WR : C_CMD_RD);
            if (cnt == 2'd1) begin
               state_nxt = S_ADDR;
               cnt_nxt   = 2'd0;
            end
         end
         S_ADDR: begin
            o_sqi_sio_oe  = 1'b1;
            o_sqi_sio_out = addr_nib;
            if (cnt == 2'd3) begin
               state_nxt = wr_q ? S_DATA : S_DUMMY;
               cnt_nxt   = 2'd0;
            end
         end
         S_DUMMY: begin
            if (cnt == 2'd1) begin
               state_nxt = S_DATA;
               cnt_nxt   = 2'd0;
            end
         end
         S_DATA: begin
            o_sqi_data_vld = 1'b1;
            if (wr_q) begin
               o_sqi_sio_oe  = 1'b1;
               o_sqi_sio_out = i_sqi_wr_data;
            end else begin
               o_sqi_rd_data = i_sqi_sio_in;
            end
            if (cnt == 2'd3) begin
               o_sqi_done = 1'b1;
               state_nxt  = S_IDLE;
               cnt_nxt    = 2'd0;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            cnt_nxt    = 2'd0;
            o_sqi_cs_n = 1'b1;
         end
      endcase
   end

   assign o_sqi_sck_en = ~o_sqi_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_m.sv
`default_nettype none
// ============================================================================
// tb_idli_sqi_m : randomized self-checking bench for idli_sqi_m.
// Revision      : 1.0
// ============================================================================
module tb_idli_sqi_m;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        wr;
   logic [15:0] addr;
   logic [3:0]  wr_data;
   logic [3:0]  sio_in;
   logic        ack, data_vld, done, cs_n, sck_en, sio_oe;
   logic [3:0]  rd_data, sio_out;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // {cs_n, sck_en, ack, oe, vld, done, sio_out, rd_data}
   logic [13:0] obs;
   assign obs = {cs_n, sck_en, ack, sio_oe, data_vld, done, sio_out, rd_data};

   localparam logic [13:0] C_IDLE_OBS = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
   localparam logic [13:0] C_ACK_OBS  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};

   idli_sqi_m dut (
      .i_sqi_gck      (clk),
      .i_sqi_rst_n    (rst_n),
      .i_sqi_req      (req),
      .i_sqi_wr       (wr),
      .i_sqi_addr     (addr),
      .o_sqi_ack      (ack),
      .i_sqi_wr_data  (wr_data),
      .o_sqi_rd_data  (rd_data),
      .o_sqi_data_vld (data_vld),
      .o_sqi_done     (done),
      .o_sqi_cs_n     (cs_n),
      .o_sqi_sck_en   (sck_en),
      .o_sqi_sio_out  (sio_out),
      .o_sqi_sio_oe   (sio_oe),
      .i_sqi_sio_in   (sio_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: one transfer is a fixed stream of nibbles -- command
   // {0, 3|2}, four address nibbles MSN first, two dummy cycles for reads,
   // then four data nibbles in order.
   task automatic do_transfer(input logic t_wr, input logic [15:0] t_addr,
                              input logic [15:0] t_data, input bit keep_req,
                              input bit poke, input string name, output int ack_cyc);
      int          n;
      int          dk;
      logic [3:0]  di;
      logic [13:0] exp;
      req = 1'b1; wr = t_wr; addr = t_addr;
      wr_data = 4'($urandom); sio_in = 4'($urandom);
      @(negedge clk);
      n_total++;
      if (obs !== C_ACK_OBS)
         $display("FAIL %s ack-cycle: got %h want %h", name, obs, C_ACK_OBS);
      else n_pass++;
      ack_cyc = cyc;
      @(posedge clk); #1;
      n = t_wr ? 10 : 12;
      for (int k = 0; k < n; k++) begin
         req     = keep_req || (poke && k >= 2 && k <= 5);
         wr      = 1'($urandom);
         addr    = 16'($urandom);
         wr_data = 4'($urandom);
         sio_in  = 4'($urandom);
         dk      = k - (t_wr ? 6 : 8);
         di      = 4'h0;
         if (dk >= 0) begin
            di = t_data[15 - 4*dk -: 4];
            if (t_wr) wr_data = di; else sio_in = di;
         end
         exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
         if (k < 2) begin
            exp[10]  = 1'b1;
            exp[7:4] = (k == 0) ? 4'h0 : (t_wr ? 4'h2 : 4'h3);
         end else if (k < 6) begin
            exp[10]  = 1'b1;
            exp[7:4] = t_addr[15 - 4*(k-2) -: 4];
         end else if (dk >= 0) begin
            exp[9] = 1'b1;
            exp[8] = (dk == 3);
            if (t_wr) begin
               exp[10]  = 1'b1;
               exp[7:4] = di;
            end else begin
               exp[3:0] = di;
            end
         end
         @(negedge clk);
         n_total++;
         if (obs !== exp)
            $display("FAIL %s cycle %0d: got %h want %h", name, k + 1, obs, exp);
         else n_pass++;
         @(posedge clk); #1;
      end
      req = keep_req;
   endtask

   task automatic idle_cycles(input int m, input string name);
      for (int i = 0; i < m; i++) begin
         req = 1'b0; addr = 16'($urandom); sio_in = 4'($urandom); wr_data = 4'($urandom);
         @(negedge clk);
         n_total++;
         if (obs !== C_IDLE_OBS)
            $display("FAIL %s idle: got %h want %h", name, obs, C_IDLE_OBS);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      int a;
      rst_n = 1'b0; req = 1'b1; wr = 1'b0; addr = 16'h1234;
      wr_data = 4'hF; sio_in = 4'hF;
      #1;
      n_total++;
      if (obs !== C_IDLE_OBS)
         $display("FAIL reset_state: got %h want %h", obs, C_IDLE_OBS);
      else n_pass++;
      @(negedge clk);
      req = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      a = 0;
   endtask

   task automatic test_read_directed();
      int a;
      do_transfer(1'b0, 16'hA5C3, 16'h1234, 1'b0, 1'b0, "read_a5c3", a);
      idle_cycles(1, "read_a5c3");
   endtask

   task automatic test_write_directed();
      int a;
      do_transfer(1'b1, 16'h0010, 16'hFEDC, 1'b0, 1'b0, "write_0010", a);
      idle_cycles(1, "write_0010");
   endtask

   task automatic test_random();
      int a;
      for (int i = 0; i < 8; i++) begin
         do_transfer(1'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0, "random", a);
         idle_cycles($urandom_range(1, 3), "random");
      end
   endtask

   task automatic test_back_to_back();
      int a0, a1, a2;
      do_transfer(1'b0, 16'($urandom), 16'($urandom), 1'b1, 1'b0, "b2b", a0);
      do_transfer(1'b0, 16'($urandom), 16'($urandom), 1'b1, 1'b0, "b2b", a1);
      do_transfer(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, "b2b", a2);
      n_total++;
      if ((a1 - a0) !== 13 || (a2 - a1) !== 13)
         $display("FAIL b2b_ack_spacing: got %0d,%0d want 13,13", a1 - a0, a2 - a1);
      else n_pass++;
      idle_cycles(1, "b2b");
   endtask

   task automatic test_req_during_addr();
      int a;
      do_transfer(1'b0, 16'h5A3C, 16'($urandom), 1'b0, 1'b1, "poke_addr_rd", a);
      idle_cycles(1, "poke_addr_rd");
      do_transfer(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, "poke_addr_wr", a);
      idle_cycles(1, "poke_addr_wr");
   endtask

   task automatic test_reset_mid();
      int a;
      req = 1'b1; wr = 1'b0; addr = 16'hBEEF;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      n_total++;
      if (cs_n !== 1'b0)
         $display("FAIL reset_mid_pre: cs_n got %b want 0", cs_n);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (obs !== C_IDLE_OBS)
         $display("FAIL reset_mid_abort: got %h want %h", obs, C_IDLE_OBS);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (obs !== C_IDLE_OBS)
         $display("FAIL reset_mid_hold: got %h want %h", obs, C_IDLE_OBS);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      idle_cycles(1, "reset_mid_release");
      do_transfer(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, "reset_mid_write", a);
      idle_cycles(1, "reset_mid_write");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_read_directed();
      test_write_directed();
      test_random();
      test_back_to_back();
      test_req_during_addr();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
